// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width, busy-rise timeout
// and the scheduler state encoding.
package uart_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned BUSY_RISE_TIMEOUT = 4;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StGrant  = 3'd1,
        StSend   = 3'd2,
        StWaitHi = 3'd3,
        StWaitLo = 3'd4,
        StGap    = 3'd5
    } state_e;

    // Counter width able to hold 0..val-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned val);
        return (val > 1) ? $clog2(val) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and UART-core signal bundle of the transmit scheduler.
// master is the scheduler side; slave is the requester/UART-core side.
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned LEN_W = 3
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic [N_REQ*BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        frame_done;
    logic                    tx_start;
    logic [BYTE_W-1:0]       tx_data;
    logic                    tx_busy;
    logic                    busy;

    modport master (
        input  req,
        input  req_len,
        input  req_data,
        input  tx_busy,
        output req_ack,
        output gnt,
        output frame_done,
        output tx_start,
        output tx_data,
        output busy
    );

    modport slave (
        output req,
        output req_len,
        output req_data,
        output tx_busy,
        input  req_ack,
        input  gnt,
        input  frame_done,
        input  tx_start,
        input  tx_data,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first asserted request at or after the pointer
// (wrapping) wins. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int unsigned cand;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(pointer) + k) % N_REQ;
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ frame producers.
// Bytes are paced by the transmitter's busy flag; frames are separated by GAP_CYC idle cycles.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned LEN_W   = 3,
    parameter int unsigned GAP_CYC = 16
) (
    input logic             clk,
    input logic             rst,
    uart_tx_sched_if.master bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned GAP_W = cnt_width(GAP_CYC);
    localparam int unsigned TO_W  = cnt_width(BUSY_RISE_TIMEOUT);

    localparam logic [GAP_W-1:0] GapLast = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TO_W-1:0]  HiLast  = TO_W'(BUSY_RISE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N_REQ - 1);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;

    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic [LEN_W-1:0]  cur_len;
    logic [BYTE_W-1:0] cur_data;
    logic [N_REQ-1:0]  req_ack;
    logic [N_REQ-1:0]  frame_done;
    logic              tx_start;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.req),
        .pointer (ptr_q),
        .enable  (state_q == StIdle),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    assign cur_len  = bus.req_len[32'(idx_q) * LEN_W +: LEN_W];
    assign cur_data = bus.req_data[32'(idx_q) * BYTE_W +: BYTE_W];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        tx_data_d  = tx_data_q;
        req_ack    = '0;
        frame_done = '0;
        tx_start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Grant is registered here so it is visible in the GRANT cycle.
                if (|bus.req) begin
                    idx_d   = arb_idx;
                    gnt_d   = arb_grant;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                byte_cnt_d = cur_len;
                state_d    = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    tx_start  = 1'b1;
                    tx_data_d = cur_data;
                    req_ack   = gnt_q;
                    hi_cnt_d  = '0;
                    state_d   = StWaitHi;
                end
            end
            StWaitHi: begin
                // A core that never raises busy is treated as having sent the byte.
                if (bus.tx_busy || (hi_cnt_q == HiLast)) begin
                    state_d = StWaitLo;
                end else begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!bus.tx_busy) begin
                    if (byte_cnt_q == '0) begin
                        frame_done = gnt_q;
                        gnt_d      = '0;
                        ptr_d      = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                        gap_cnt_d  = '0;
                        state_d    = (GAP_CYC == 0) ? StIdle : StGap;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 1'b1;
                        state_d    = StSend;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // tx_data shows the byte combinationally in the start cycle, then holds it.
    assign bus.tx_data    = tx_start ? cur_data : tx_data_q;
    assign bus.tx_start   = tx_start;
    assign bus.req_ack    = req_ack;
    assign bus.frame_done = frame_done;
    assign bus.gnt        = gnt_q;
    assign bus.busy       = (state_q != StIdle);

    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_done_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(frame_done));
    a_ack_granted : assert property (@(posedge clk) disable iff (rst) (req_ack & ~gnt_q) == '0);

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART byte transmitter among N_REQ frame producers, e.g. the divider result path and a status/echo path.
- Grants one requester for a whole frame of 1..2^LEN_W bytes.
- Issues one tx_start pulse per byte and paces bytes on the transmitter's busy flag instead of a fixed baud-period counter.
- Sits between the per-function controllers and the UART TX core.

Parameters:
N_REQ, 2, number of requesters (2..8)
LEN_W, 3, width of per-requester frame length field (length-1 encoding)
GAP_CYC, 16, idle cycles enforced between frames (0 = no gap)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  requester i has a frame pending (level)
req_len  in  N_REQ*LEN_W  frame length minus 1 for requester i, slice i at [i*LEN_W +: LEN_W]
req_data  in  N_REQ*8  current byte of requester i, slice [i*8 +: 8]
req_ack  out  N_REQ  1-cycle pulse: granted requester's current byte taken; requester presents next byte on the following cycle
gnt  out  N_REQ  one-hot grant, held for the whole frame
frame_done  out  N_REQ  1-cycle pulse when the granted frame's last byte has finished transmitting
tx_start  out  1  1-cycle pulse to UART TX core
tx_data  out  8  byte to transmit, valid when tx_start=1 and held until the next tx_start
tx_busy  in  1  UART TX core busy (high while shifting a byte)
busy  out  1  scheduler not in IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; gnt=0, req_ack=0, frame_done=0, tx_start=0, tx_data=8'h00, busy=0; RR pointer=0; byte and gap counters=0.
- Reset mid-frame aborts the frame with no frame_done. Any byte already started on the UART core is not recalled.
- States: IDLE, GRANT, SEND, WAIT_HI, WAIT_LO, GAP.
- IDLE: if |req, pick the winner by round-robin (below); go to GRANT. Otherwise stay.
- GRANT: gnt=onehot(winner) (registered, so it appears 1 cycle after req is seen); byte_cnt<=req_len[winner]; go to SEND.
- SEND: if tx_busy=0, drive tx_start=1 for this cycle and tx_data<=req_data[winner]; req_ack[winner]=1 for this cycle; go to WAIT_HI. If tx_busy=1, hold in SEND.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. The core must raise busy within 1..4 cycles of tx_start. If busy is still low after 4 cycles, treat the byte as sent and go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0.
  - If byte_cnt==0: frame_done[winner]=1 for one cycle, gnt<=0, pointer<=winner+1 (mod N_REQ); go to GAP, or to IDLE if GAP_CYC=0.
  - Otherwise byte_cnt<=byte_cnt-1 and go to SEND.
- GAP: count GAP_CYC cycles, then go to IDLE. req is ignored during GAP.
- Round-robin: search starts at the pointer and wraps, so the first asserted req at or after the pointer wins. After reset index 0 has highest priority.
- Requester drops req mid-frame: ignored; the frame completes with whatever req_data is presented. req_len is sampled only in GRANT.
- Simultaneous requests: exactly one grant. The loser keeps req high and wins next unless a third requester sits between them in RR order.
- Latency for an idle system with tx_busy=0: req at cycle t → gnt at t+1 → tx_start at t+2.
- Minimum inter-byte spacing is set by tx_busy; there is no internal baud counter.
- gnt and frame_done are never asserted for two requesters at once. req_ack is asserted only on the granted index.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE..GAP)
  - BYTE_W=8
  - BUSY_RISE_TIMEOUT=4
- One sub-module, rr_arbiter (N_REQ param): inputs req, pointer, enable; outputs one-hot grant and encoded index. Combinational search, with the pointer register living in uart_tx_sched.

Test Plan:
1. Single requester: req=2'b01, req_len[0]=3, bytes A1,A2,A3,A4; TX model raises busy 1 cycle after start and holds it 10 cycles. Expect exactly 4 tx_start pulses with data A1..A4, 4 req_ack[0] pulses, then 1 frame_done[0] pulse after the 4th busy fall, gnt=01 throughout.
2. Contention/fairness: req=2'b11 held continuously, len=0 for both. Grants alternate 01,10,01,10 over 4 frames, with ≥GAP_CYC=16 idle cycles between each frame's frame_done and the next gnt.
3. Busy backpressure: tx_busy forced high when SEND is entered. tx_start is held off until busy falls, then fires exactly once; no duplicate req_ack.
4. Busy never rises: TX model ignores tx_start for 1 byte. The scheduler advances after 4 cycles of WAIT_HI, and a len=0 frame completes with frame_done.
5. Reset mid-frame: rst=1 for 1 cycle during the 2nd byte of a 4-byte frame. Next cycle gnt=0, tx_start=0, busy=0, no frame_done, pointer=0; a subsequent req=2'b11 grants index 0.
6. Max length / req drop: len=7, req[1] deasserted after the first byte. All 8 bytes still sent and frame_done[1] pulses once.
